// File: rtl/msrv32_pkg.sv
// Shared types and constants for the msrv32 integer writeback path.
package msrv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // (base + off) mod n for base, off < n, without a divider.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/msrv32_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after rr_ptr, and
// moves the pointer one past the grantee whenever a grant is issued.
module msrv32_rr_arbiter
  import msrv32_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               ms_riscv32_mp_clk_in,
  input  logic               ms_riscv32_mp_rst_in,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] rr_ptr;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    if (en) begin
      // Scan farthest-first so the nearest valid source after rr_ptr wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req[wrap_idx(int'(rr_ptr), k, NUM_REQ)]) begin
          grant_idx   = IDX_W'(wrap_idx(int'(rr_ptr), k, NUM_REQ));
          grant_valid = 1'b1;
        end
      end
      if (grant_valid) grant[grant_idx] = 1'b1;
    end
  end

  // A grant is only ever given to a valid source, so every grant is a transfer.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      // NOTE: state is updated with <= so every flop samples pre-edge values.
      rr_ptr <= IDX_W'(wrap_idx(int'(grant_idx), 1, NUM_REQ));
    end
  end

endmodule

// File: rtl/msrv32_wb_arbiter.sv
// Shares the register-file write port between writeback sources and keeps
// the pending-write scoreboard that decode uses for RAW hazard stalls.
module msrv32_wb_arbiter
  import msrv32_pkg::REG_ADDR_W;
  import msrv32_pkg::NUM_REGS;
  import msrv32_pkg::wb_req_t;
#(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
) (
  input  logic                        ms_riscv32_mp_clk_in,
  input  logic                        ms_riscv32_mp_rst_in,
  input  logic [NUM_REQ-1:0]          req_valid_in,
  input  logic [REG_ADDR_W*NUM_REQ-1:0] req_rd_addr_in,
  input  logic [XLEN*NUM_REQ-1:0]     req_data_in,
  output logic [NUM_REQ-1:0]          req_ready_out,
  input  logic                        hold_in,
  input  logic                        alloc_en_in,
  input  logic [REG_ADDR_W-1:0]       alloc_addr_in,
  input  logic [REG_ADDR_W-1:0]       rs_1_addr_in,
  input  logic [REG_ADDR_W-1:0]       rs_2_addr_in,
  output logic                        rs_1_busy_out,
  output logic                        rs_2_busy_out,
  output logic                        wr_en_out,
  output logic [REG_ADDR_W-1:0]       rd_addr_out,
  output logic [XLEN-1:0]             rd_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_valid;
  wb_req_t             sel;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  // Grants are also suppressed while reset is low so no source sees ready.
  msrv32_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .ms_riscv32_mp_clk_in (ms_riscv32_mp_clk_in),
    .ms_riscv32_mp_rst_in (ms_riscv32_mp_rst_in),
    .req                  (req_valid_in),
    .en                   (!hold_in && ms_riscv32_mp_rst_in),
    .grant                (grant),
    .grant_idx            (grant_idx),
    .grant_valid          (grant_valid)
  );

  assign req_ready_out = grant;

  always_comb begin
    sel.valid   = grant_valid;
    sel.rd_addr = req_rd_addr_in[REG_ADDR_W*grant_idx +: REG_ADDR_W];
    sel.data    = req_data_in[XLEN*grant_idx +: XLEN];
  end

  // Clear on writeback, then set on allocate, so a same-edge collision stays busy.
  always_comb begin
    busy_nxt = busy;
    if (sel.valid) busy_nxt[sel.rd_addr] = 1'b0;
    if (alloc_en_in) busy_nxt[alloc_addr_in] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      // NOTE: the scoreboard is a flop vector rather than a RAM, so it can and
      // must clear on reset; stale busy bits would stall decode forever.
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      wr_en_out   <= 1'b0;
      rd_addr_out <= '0;
      rd_out      <= '0;
    end else begin
      wr_en_out <= 1'b0;
      if (sel.valid) begin
        rd_addr_out <= sel.rd_addr;
        rd_out      <= sel.data;
        wr_en_out   <= (sel.rd_addr != '0);
      end
    end
  end

  assign rs_1_busy_out = busy[rs_1_addr_in];
  assign rs_2_busy_out = busy[rs_2_addr_in];

endmodule

// File: tb/tb_msrv32_wb_arbiter.sv
// Randomized scoreboard bench for msrv32_wb_arbiter against a queue-and-array
// reference model of round-robin writeback and the pending-write set.
module tb_msrv32_wb_arbiter;

  localparam int N  = 3;
  localparam int XL = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid_in;
  logic [5*N-1:0]    req_rd_addr_in;
  logic [XL*N-1:0]   req_data_in;
  logic [N-1:0]      req_ready_out;
  logic              hold_in;
  logic              alloc_en_in;
  logic [4:0]        alloc_addr_in;
  logic [4:0]        rs_1_addr_in;
  logic [4:0]        rs_2_addr_in;
  logic              rs_1_busy_out;
  logic              rs_2_busy_out;
  logic              wr_en_out;
  logic [4:0]        rd_addr_out;
  logic [XL-1:0]     rd_out;

  msrv32_wb_arbiter #(.NUM_REQ(N), .XLEN(XL)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .req_valid_in         (req_valid_in),
    .req_rd_addr_in       (req_rd_addr_in),
    .req_data_in          (req_data_in),
    .req_ready_out        (req_ready_out),
    .hold_in              (hold_in),
    .alloc_en_in          (alloc_en_in),
    .alloc_addr_in        (alloc_addr_in),
    .rs_1_addr_in         (rs_1_addr_in),
    .rs_2_addr_in         (rs_2_addr_in),
    .rs_1_busy_out        (rs_1_busy_out),
    .rs_2_busy_out        (rs_2_busy_out),
    .wr_en_out            (wr_en_out),
    .rd_addr_out          (rd_addr_out),
    .rd_out               (rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          wen;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   in_reset = 1'b1;

  // Source-side state and decode-side controls.
  bit          v[N];
  logic [4:0]  a[N];
  logic [31:0] d[N];
  bit          b_hold;
  bit          b_alloc;
  logic [4:0]  b_alloc_addr;
  logic [4:0]  b_rs1;
  logic [4:0]  b_rs2;

  // Reference model: pointer as an integer, pending set as a bit array.
  int m_ptr;
  bit m_busy[32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    for (int i = 0; i < N; i++) v[i] = 1'b0;
  endtask

  // One clock of stimulus: drive at the falling edge, check the combinational
  // response, then advance the model across the coming rising edge.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid_in[i]             = v[i];
      req_rd_addr_in[5*i +: 5]    = a[i];
      req_data_in[XL*i +: XL]     = d[i];
    end
    hold_in       = b_hold;
    alloc_en_in   = b_alloc;
    alloc_addr_in = b_alloc_addr;
    rs_1_addr_in  = b_rs1;
    rs_2_addr_in  = b_rs2;
    #1;
    g = -1;
    if (!b_hold) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check("ready", req_ready_out, exp_rdy);
    check("rs1_busy", rs_1_busy_out, m_busy[b_rs1]);
    check("rs2_busy", rs_2_busy_out, m_busy[b_rs2]);
    if (g >= 0) begin
      sb.push_back('{cyc + 1, a[g] != 5'd0, a[g], d[g]});
      m_ptr = (g + 1) % N;
      m_busy[a[g]] = 1'b0;
      v[g] = 1'b0;
    end
    if (b_alloc && b_alloc_addr != 5'd0) m_busy[b_alloc_addr] = 1'b1;
  endtask

  task automatic drain();
    for (int t = 0; t < 4 * N; t++) begin
      if (v[0] || v[1] || v[2]) cycle();
    end
  endtask

  // Monitor: after every rising edge, the write port must show exactly the
  // transfer scheduled for this cycle, or idle with the last values held.
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  exp_t        mon_e;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (in_reset) begin
      check("reset wr_en", wr_en_out, 0);
      check("reset rd_addr", rd_addr_out, 0);
      check("reset rd", rd_out, 0);
      sb.delete();
      last_addr = '0;
      last_data = '0;
    end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      check("wr_en", wr_en_out, mon_e.wen);
      check("rd_addr", rd_addr_out, mon_e.addr);
      check("rd", rd_out, mon_e.data);
      last_addr = mon_e.addr;
      last_data = mon_e.data;
    end else begin
      check("idle wr_en", wr_en_out, 0);
      check("hold rd_addr", rd_addr_out, last_addr);
      check("hold rd", rd_out, last_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    req_valid_in   = '1;
    req_rd_addr_in = '0;
    req_data_in    = '0;
    hold_in        = 1'b0;
    alloc_en_in    = 1'b0;
    alloc_addr_in  = '0;
    rs_1_addr_in   = '0;
    rs_2_addr_in   = '0;
    b_hold = 0; b_alloc = 0; b_alloc_addr = '0; b_rs1 = '0; b_rs2 = '0;
    for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
    model_reset();

    // Ready stays low under reset even with every source requesting.
    repeat (2) begin
      @(negedge clk); #1;
      check("ready in reset", req_ready_out, 0);
    end
    @(negedge clk);
    rst_n = 1'b1; in_reset = 1'b0; req_valid_in = '0;

    // Round robin with all sources continuously valid: 0,1,2,0,1,2.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i]) begin v[i] = 1; a[i] = 5'(i + 1); d[i] = $urandom; end
      end
      cycle();
      check("rr order", req_ready_out, N'(1) << (k % N));
    end
    drain();

    // Scoreboard set by allocate, cleared by the writeback of x7.
    b_alloc = 1; b_alloc_addr = 5'd7; cycle();
    b_alloc = 0; b_rs1 = 5'd7; cycle();
    check("x7 busy after alloc", rs_1_busy_out, 1);
    v[1] = 1; a[1] = 5'd7; d[1] = 32'hDEADBEEF; cycle();
    check("x7 grant src1", req_ready_out, 3'b010);
    cycle();
    check("x7 busy after write", rs_1_busy_out, 0);

    // Allocate and writeback of x9 on one edge: set wins.
    b_alloc = 1; b_alloc_addr = 5'd9; cycle();
    v[0] = 1; a[0] = 5'd9; d[0] = $urandom; cycle();
    b_alloc = 0; b_rs2 = 5'd9; cycle();
    check("x9 collision busy", rs_2_busy_out, 1);

    // x0 write handshakes but never writes; allocating x0 never marks busy.
    v[2] = 1; a[2] = 5'd0; d[2] = 32'h12345678;
    b_alloc = 1; b_alloc_addr = 5'd0; cycle();
    check("x0 ready", req_ready_out, 3'b100);
    b_alloc = 0; b_rs1 = 5'd0; cycle();
    check("x0 busy", rs_1_busy_out, 0);
    check("x0 no write", wr_en_out, 0);

    // Hold blocks grants; release resumes from the saved pointer.
    v[0] = 1; a[0] = 5'd3; d[0] = $urandom;
    v[2] = 1; a[2] = 5'd4; d[2] = $urandom;
    b_hold = 1;
    repeat (4) begin
      cycle();
      check("hold no grant", req_ready_out, 0);
    end
    b_hold = 0;
    cycle(); check("after hold first", req_ready_out, 3'b001);
    cycle(); check("after hold second", req_ready_out, 3'b100);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && ($urandom % 2 == 0)) begin
          v[i] = 1;
          a[i] = ($urandom % 5 == 0) ? 5'd0 : 5'($urandom % 32);
          d[i] = $urandom;
        end
      end
      b_hold       = ($urandom % 6 == 0);
      b_alloc      = ($urandom % 3 == 0);
      b_alloc_addr = 5'($urandom % 32);
      b_rs1        = 5'($urandom % 32);
      b_rs2        = 5'($urandom % 32);
      cycle();
    end
    b_hold = 0; b_alloc = 0;
    drain();

    // Reset asserted while a write is registered and x5 is pending.
    b_alloc = 1; b_alloc_addr = 5'd5;
    v[0] = 1; a[0] = 5'd6; d[0] = 32'hA5A5_0F0F; cycle();
    b_alloc = 0;
    @(negedge clk);
    rs_1_addr_in = 5'd5; req_valid_in = '0;
    #1;
    check("pre-reset x5 busy", rs_1_busy_out, 1);
    check("pre-reset wr_en", wr_en_out, 1);
    in_reset = 1'b1; rst_n = 1'b0; req_valid_in = '1;
    #1;
    check("async reset busy", rs_1_busy_out, 0);
    check("async reset wr_en", wr_en_out, 0);
    check("async reset rd", rd_out, 0);
    check("async reset ready", req_ready_out, 0);
    repeat (2) begin
      @(negedge clk); #1;
      check("ready in reset", req_ready_out, 0);
    end
    @(negedge clk);
    rst_n = 1'b1; in_reset = 1'b0; req_valid_in = '0;
    model_reset();

    // Post-reset traffic starts again from pointer 0.
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && ($urandom % 2 == 0)) begin
          v[i] = 1; a[i] = 5'($urandom % 32); d[i] = $urandom;
        end
      end
      b_alloc = ($urandom % 3 == 0); b_alloc_addr = 5'($urandom % 32);
      b_rs1 = 5'($urandom % 32); b_rs2 = 5'($urandom % 32);
      cycle();
    end
    b_alloc = 0;
    drain();
    repeat (3) cycle();
    check("scoreboard drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
